// File: rtl/seat_release_sched.sv
// Daily seat-release sweeper driven by the hour/minute time stream.
// Optional macro SEAT_ACK_TIMEOUT_EN: skip a seat whose ack never arrives.
module seat_release_sched #(
  parameter int N_SEATS      = 64,
  parameter int ADDR_W       = 6,
  parameter int RST_HOUR_DEF = 0,
  parameter int ACK_TMO      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              time_valid,
  input  logic [4:0]        hour_in,
  input  logic [5:0]        min_in,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_hour,
  input  logic              clr_ack,
  output logic              clr_req,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy,
  output logic              done,
  output logic [4:0]        rel_hour,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SEATS - 1);

  state_t state;
  logic   fired;
  logic   accepted;
  logic   cfg_ok;
  logic   trig;
  logic   adv;
  logic   tmo;

  assign accepted = time_valid
                  && (hour_in <= 5'd23)
                  && (min_in <= 6'd59);
  assign cfg_ok   = cfg_we && (cfg_hour <= 5'd23);
  // Compared against the pre-write hour, so a same-cycle write never retargets it
  assign trig     = accepted
                  && (hour_in == rel_hour)
                  && (min_in == 6'd0)
                  && !fired;

`ifdef SEAT_ACK_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TMO + 1);
  logic [TW-1:0] cnt;
  assign tmo = (state == SWEEP) && !clr_ack
             && (cnt == TW'(ACK_TMO - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (ACK_TMO > 0);
  assign tmo        = 1'b0;
`endif

  assign adv = clr_ack || tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fired    <= 1'b0;
      rel_hour <= 5'(RST_HOUR_DEF);
      clr_req  <= 1'b0;
      clr_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (cfg_ok)
        rel_hour <= cfg_hour;
      if (trig)
        fired <= 1'b1;
      else if (cfg_ok || (accepted && hour_in != rel_hour))
        fired <= 1'b0;
      if (tmo)
        err <= 1'b1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (trig) begin
            state    <= SWEEP;
            clr_req  <= 1'b1;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
        SWEEP: begin
          if (adv) begin
            if (clr_addr == LAST) begin
              state    <= DONE;
              clr_req  <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              clr_addr <= '0;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          clr_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEAT_ACK_TIMEOUT_EN
  // Restarts for every newly presented address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state != SWEEP || adv)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_seat_release_sched.sv
// Directed bench for seat_release_sched.
// Build with SEAT_ACK_TIMEOUT_EN to exercise the ack-timeout variant.
module tb_seat_release_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       time_valid;
  logic [4:0] hour_in;
  logic [5:0] min_in;
  logic       cfg_we;
  logic [4:0] cfg_hour;
  logic       clr_ack;
  logic       clr_req;
  logic [5:0] clr_addr;
  logic       busy;
  logic       done;
  logic [4:0] rel_hour;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;

  seat_release_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_valid (time_valid),
    .hour_in    (hour_in),
    .min_in     (min_in),
    .cfg_we     (cfg_we),
    .cfg_hour   (cfg_hour),
    .clr_ack    (clr_ack),
    .clr_req    (clr_req),
    .clr_addr   (clr_addr),
    .busy       (busy),
    .done       (done),
    .rel_hour   (rel_hour),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (done) n_done++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int h, input int m);
    time_valid = 1'b1;
    hour_in    = 5'(h);
    min_in     = 6'(m);
    tick();
    time_valid = 1'b0;
  endtask

  task automatic cfg(input int h);
    cfg_we   = 1'b1;
    cfg_hour = 5'(h);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    chk(tag, int'(done), 1);
    tick();
  endtask

  initial begin
    int d0;
    rst_n      = 1'b0;
    time_valid = 1'b0;
    hour_in    = '0;
    min_in     = '0;
    cfg_we     = 1'b0;
    cfg_hour   = '0;
    clr_ack    = 1'b1;
    tick(2);
    chk("rst_req", int'(clr_req), 0);
    chk("rst_addr", int'(clr_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_hour", int'(rel_hour), 0);
    rst_n = 1'b1;
    tick();

    // 1: full sweep at 00:00, ack held high
    sample(0, 0);
    chk("t1_busy", int'(busy), 1);
    for (int i = 0; i < 64; i++) begin
      chk("t1_req", int'(clr_req), 1);
      chk("t1_addr", int'(clr_addr), i);
      tick();
    end
    chk("t1_done", int'(done), 1);
    chk("t1_busy_lo", int'(busy), 0);
    chk("t1_req_lo", int'(clr_req), 0);
    chk("t1_addr0", int'(clr_addr), 0);
    tick();
    chk("t1_done_1cyc", int'(done), 0);

    // 2: one sweep per day
    cfg(7);
    chk("t2_hour", int'(rel_hour), 7);
    d0 = n_done;
    sample(7, 0);
    wait_done("t2_sweep1");
    sample(7, 0);
    tick();
    chk("t2_no_rep", int'(busy), 0);
    sample(7, 1);
    tick();
    chk("t2_min1", int'(busy), 0);
    chk("t2_count", n_done - d0, 1);
    sample(8, 0);
    sample(7, 0);
    chk("t2_day2", int'(busy), 1);
    wait_done("t2_sweep2");
    chk("t2_count2", n_done - d0, 2);

    // 3: ack stall at addr 10
    cfg(9);
    sample(9, 0);
    tick(10);
    chk("t3_at10", int'(clr_addr), 10);
    clr_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_req", int'(clr_req), 1);
      chk("t3_hold_addr", int'(clr_addr), 10);
    end
    clr_ack = 1'b1;
    tick();
    chk("t3_adv", int'(clr_addr), 11);
    wait_done("t3_done");

    // 4: illegal config and time samples
    cfg(30);
    chk("t4_cfg30", int'(rel_hour), 9);
    cfg(5);
    sample(5, 60);
    tick();
    chk("t4_min60", int'(busy), 0);
    sample(24, 0);
    tick();
    chk("t4_hr24", int'(busy), 0);
    sample(5, 0);
    chk("t4_legal", int'(busy), 1);
    wait_done("t4_done");

    // 5: reset mid-sweep
    cfg(6);
    sample(6, 0);
    tick(20);
    chk("t5_at20", int'(clr_addr), 20);
    rst_n = 1'b0;
    #1;
    chk("t5_req", int'(clr_req), 0);
    chk("t5_addr", int'(clr_addr), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_hour", int'(rel_hour), 0);
    tick();
    rst_n = 1'b1;
    tick(5);
    chk("t5_no_resume", int'(busy), 0);
    chk("t5_no_req", int'(clr_req), 0);

    // 6: no ack at addr 3
    sample(0, 0);
    tick(3);
    chk("t6_at3", int'(clr_addr), 3);
    clr_ack = 1'b0;
    tick(14);
    chk("t6_hold14", int'(clr_addr), 3);
`ifdef SEAT_ACK_TIMEOUT_EN
    tick();
    chk("t6_skip", int'(clr_addr), 4);
    chk("t6_err", int'(err), 1);
`else
    tick(20);
    chk("t6_hold", int'(clr_addr), 3);
    chk("t6_err0", int'(err), 0);
`endif
    clr_ack = 1'b1;
    wait_done("t6_done");
`ifdef SEAT_ACK_TIMEOUT_EN
    chk("t6_sticky", int'(err), 1);
`else
    chk("t6_err_end", int'(err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
